// File: rtl/gate_scheduler.sv
// Gate scheduler: sweeps the netlist gate rows once per circuit cycle and issues one
// job per cycle over valid/ready. Optional issued-gate statistics under GATE_STATS_EN.
module gate_scheduler #(
    parameter int S   = 14,
    parameter int CCW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CCW-1:0]   num_cc,
    input  logic [S-1:0]     init_size,
    input  logic [S-1:0]     input_size,
    input  logic [S-1:0]     dff_size,
    input  logic [S-1:0]     gate_size,
    input  logic [S-1:0]     in0,
    input  logic [S-1:0]     in1,
    input  logic             in0F,
    input  logic             in1F,
    input  logic [3:0]       g_logic,
    input  logic             is_output,
    output logic [S-1:0]     rd_addr,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [S-1:0]     job_in0,
    output logic [S-1:0]     job_in1,
    output logic             job_in0F,
    output logic             job_in1F,
    output logic             job_is_output,
    output logic [3:0]       job_g_logic,
    output logic [S-1:0]     job_wire,
    output logic             job_last,
    output logic [CCW-1:0]   job_cc,
    output logic             busy,
    output logic             done,
    output logic [S+CCW-1:0] xor_cnt,
    output logic [S+CCW-1:0] nonxor_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [S-1:0]   ONE_S  = 1;
    localparam logic [CCW-1:0] ONE_CC = 1;

    state_t         state_q, state_d;
    logic [S-1:0]   row_q, row_d;
    logic [CCW-1:0] cc_q, cc_d, cc_max_q, cc_max_d;
    logic           valid_q, valid_d;
    logic           empty_done_q, empty_done_d;
    logic [S-1:0]   in0_q, in0_d, in1_q, in1_d, wire_q, wire_d;
    logic           in0f_q, in0f_d, in1f_q, in1f_d, out_q, out_d, last_q, last_d;
    logic [3:0]     gl_q, gl_d;
    logic [CCW-1:0] jcc_q, jcc_d;

    logic [S-1:0] last_row;
    logic         is_last_row, load, accept;

    assign last_row    = dff_size + gate_size - ONE_S;
    assign is_last_row = (row_q == last_row);
    assign load        = (state_q == RUN) && (!valid_q || job_ready);
    assign accept      = valid_q && job_ready;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cc_d         = cc_q;
        cc_max_d     = cc_max_q;
        valid_d      = valid_q;
        empty_done_d = 1'b0;
        in0_d        = in0_q;
        in1_d        = in1_q;
        in0f_d       = in0f_q;
        in1f_d       = in1f_q;
        out_d        = out_q;
        gl_d         = gl_q;
        wire_d       = wire_q;
        last_d       = last_q;
        jcc_d        = jcc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (gate_size == '0) begin
                        empty_done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        row_d    = dff_size;
                        cc_d     = '0;
                        cc_max_d = (num_cc == '0) ? '0 : num_cc - ONE_CC;
                    end
                end
            end
            RUN: begin
                if (load) begin
                    valid_d = 1'b1;
                    in0_d   = in0;
                    in1_d   = in1;
                    in0f_d  = in0F;
                    in1f_d  = in1F;
                    out_d   = is_output;
                    gl_d    = g_logic;
                    // Gate outputs follow circuit inputs and DFF outputs in wire numbering.
                    wire_d  = init_size + input_size + dff_size + (row_q - dff_size);
                    last_d  = is_last_row;
                    jcc_d   = cc_q;
                    if (is_last_row) begin
                        if (cc_q < cc_max_q) begin
                            row_d = dff_size;
                            cc_d  = cc_q + ONE_CC;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        row_d = row_q + ONE_S;
                    end
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            cc_q         <= '0;
            cc_max_q     <= '0;
            valid_q      <= 1'b0;
            empty_done_q <= 1'b0;
            in0_q        <= '0;
            in1_q        <= '0;
            in0f_q       <= 1'b0;
            in1f_q       <= 1'b0;
            out_q        <= 1'b0;
            gl_q         <= '0;
            wire_q       <= '0;
            last_q       <= 1'b0;
            jcc_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cc_q         <= cc_d;
            cc_max_q     <= cc_max_d;
            valid_q      <= valid_d;
            empty_done_q <= empty_done_d;
            in0_q        <= in0_d;
            in1_q        <= in1_d;
            in0f_q       <= in0f_d;
            in1f_q       <= in1f_d;
            out_q        <= out_d;
            gl_q         <= gl_d;
            wire_q       <= wire_d;
            last_q       <= last_d;
            jcc_q        <= jcc_d;
        end
    end

    assign rd_addr       = (state_q == RUN) ? row_q : '0;
    assign job_valid     = valid_q;
    assign job_in0       = in0_q;
    assign job_in1       = in1_q;
    assign job_in0F      = in0f_q;
    assign job_in1F      = in1f_q;
    assign job_is_output = out_q;
    assign job_g_logic   = gl_q;
    assign job_wire      = wire_q;
    assign job_last      = last_q;
    assign job_cc        = jcc_q;
    assign busy          = (state_q != IDLE);
    assign done          = empty_done_q || ((state_q == DRAIN) && accept);

`ifdef GATE_STATS_EN
    logic [S+CCW-1:0] xor_q, xor_d, nonxor_q, nonxor_d;
    logic             is_xor;

    assign is_xor = (gl_q == 4'b0110) || (gl_q == 4'b1001);

    always_comb begin
        xor_d    = xor_q;
        nonxor_d = nonxor_q;
        if ((state_q == IDLE) && start) begin
            xor_d    = '0;
            nonxor_d = '0;
        end else if (accept) begin
            if (is_xor && (xor_q != '1))
                xor_d = xor_q + 1'b1;
            if (!is_xor && (nonxor_q != '1))
                nonxor_d = nonxor_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q    <= '0;
            nonxor_q <= '0;
        end else begin
            xor_q    <= xor_d;
            nonxor_q <= nonxor_d;
        end
    end

    assign xor_cnt    = xor_q;
    assign nonxor_cnt = nonxor_q;
`else
    assign xor_cnt    = '0;
    assign nonxor_cnt = '0;
`endif
endmodule

// File: tb/tb_gate_scheduler.sv
// Bench for gate_scheduler: table-driven scenarios plus randomized circuits and
// ready patterns, all checked against a job-list model built from the circuit parameters.
`timescale 1ns/1ps
module tb_gate_scheduler;
    localparam int S   = 14;
    localparam int CCW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, job_ready;
    logic [CCW-1:0]   num_cc;
    logic [S-1:0]     init_size, input_size, dff_size, gate_size;
    logic [S-1:0]     in0, in1, rd_addr, job_in0, job_in1, job_wire;
    logic             in0F, in1F, is_output, job_valid, job_in0F, job_in1F, job_is_output;
    logic             job_last, busy, done;
    logic [3:0]       g_logic, job_g_logic;
    logic [CCW-1:0]   job_cc;
    logic [S+CCW-1:0] xor_cnt, nonxor_cnt;

    // Behavioural netlist store: fields presented combinationally for rd_addr.
    logic [S-1:0] m_in0 [64];
    logic [S-1:0] m_in1 [64];
    logic         m_in0F[64];
    logic         m_in1F[64];
    logic         m_out [64];
    logic [3:0]   m_gl  [64];

    assign in0       = m_in0 [rd_addr[5:0]];
    assign in1       = m_in1 [rd_addr[5:0]];
    assign in0F      = m_in0F[rd_addr[5:0]];
    assign in1F      = m_in1F[rd_addr[5:0]];
    assign is_output = m_out [rd_addr[5:0]];
    assign g_logic   = m_gl  [rd_addr[5:0]];

    gate_scheduler #(.S(S), .CCW(CCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_cc(num_cc),
        .init_size(init_size), .input_size(input_size), .dff_size(dff_size), .gate_size(gate_size),
        .in0(in0), .in1(in1), .in0F(in0F), .in1F(in1F), .g_logic(g_logic), .is_output(is_output),
        .rd_addr(rd_addr), .job_valid(job_valid), .job_ready(job_ready),
        .job_in0(job_in0), .job_in1(job_in1), .job_in0F(job_in0F), .job_in1F(job_in1F),
        .job_is_output(job_is_output), .job_g_logic(job_g_logic), .job_wire(job_wire),
        .job_last(job_last), .job_cc(job_cc), .busy(busy), .done(done),
        .xor_cnt(xor_cnt), .nonxor_cnt(nonxor_cnt)
    );

    typedef struct packed {
        logic [S-1:0]   in0;
        logic [S-1:0]   in1;
        logic           in0F;
        logic           in1F;
        logic [3:0]     gl;
        logic           outp;
        logic [S-1:0]   wire_idx;
        logic           last;
        logic [CCW-1:0] cc;
    } job_t;

    typedef struct {
        int init, inp, dff, gate, ncc;
        int ready_pct, stall_job;
        int exp_jobs, exp_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit fixed_gl = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic job_t dut_job();
        job_t j;
        j.in0 = job_in0;   j.in1 = job_in1;   j.in0F = job_in0F; j.in1F = job_in1F;
        j.gl  = job_g_logic; j.outp = job_is_output; j.wire_idx = job_wire;
        j.last = job_last; j.cc = job_cc;
        return j;
    endfunction

    task automatic run(input vec_t v, output int njobs, output int done_cyc);
        job_t q[$];
        job_t e, cur, prev;
        bit   prev_stall = 1'b0;
        bit   finished = 1'b0;
        int   stall_left = 5;
        int   ncc, xor_exp = 0, nx_exp = 0;
        for (int r = 0; r < 64; r++) begin
            m_in0[r]  = S'($urandom_range(0, 9999));
            m_in1[r]  = S'($urandom_range(0, 9999));
            m_in0F[r] = 1'($urandom);
            m_in1F[r] = 1'($urandom);
            m_out[r]  = 1'($urandom);
            if (!fixed_gl) m_gl[r] = 4'($urandom);
        end
        init_size = S'(v.init); input_size = S'(v.inp); dff_size = S'(v.dff);
        gate_size = S'(v.gate); num_cc = CCW'(v.ncc);
        // Expected job list: every gate row, swept once per circuit cycle.
        ncc = (v.ncc == 0) ? 1 : v.ncc;
        for (int c = 0; c < ncc; c++) begin
            for (int g = 0; g < v.gate; g++) begin
                e.in0 = m_in0[v.dff+g]; e.in1 = m_in1[v.dff+g];
                e.in0F = m_in0F[v.dff+g]; e.in1F = m_in1F[v.dff+g];
                e.gl = m_gl[v.dff+g]; e.outp = m_out[v.dff+g];
                e.wire_idx = S'(v.init + v.inp + v.dff + g);
                e.last = (g == v.gate - 1);
                e.cc = CCW'(c);
                q.push_back(e);
                if (e.gl == 4'b0110 || e.gl == 4'b1001) xor_exp++;
                else nx_exp++;
            end
        end
        njobs = 0;
        done_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            job_ready = ($urandom_range(0, 99) < v.ready_pct);
            if (v.stall_job > 0 && job_valid && njobs == v.stall_job - 1 && stall_left > 0) begin
                job_ready = 1'b0;
                stall_left--;
                check("stall_rd_addr", rd_addr, S'(v.dff + v.stall_job));
            end
            #1;
            cur = dut_job();
            if (c == 0) check("busy_after_start", busy, (v.gate > 0));
            if (prev_stall) begin
                check("stall_valid_held", job_valid, 1);
                check("stall_fields_held", cur, prev);
            end
            if (job_valid && job_ready) begin
                if (q.size() == 0) begin
                    check("extra_job", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("job_wire", cur.wire_idx, e.wire_idx);
                    check("job_last_cc", {cur.last, cur.cc}, {e.last, e.cc});
                    check("job_fields", cur, e);
                end
                njobs++;
            end
            prev_stall = job_valid && !job_ready;
            prev = cur;
            if (done) begin
                done_cyc = c;
                check("jobs_left_at_done", q.size(), 0);
                finished = 1'b1;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        @(negedge clk); #1;
        check("post_done_idle", {job_valid, done, busy}, 0);
`ifdef GATE_STATS_EN
        check("xor_cnt", xor_cnt, xor_exp);
        check("nonxor_cnt", nonxor_cnt, nx_exp);
`else
        check("xor_cnt_off", xor_cnt, 0);
        check("nonxor_cnt_off", nonxor_cnt, 0);
`endif
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   nj, dc, ncc;

        rst_n = 1'b0; start = 1'b0; job_ready = 1'b0; num_cc = '0;
        init_size = '0; input_size = '0; dff_size = '0; gate_size = '0;
        for (int r = 0; r < 64; r++) begin
            m_in0[r] = '0; m_in1[r] = '0; m_in0F[r] = 1'b0; m_in1F[r] = 1'b0;
            m_out[r] = 1'b0; m_gl[r] = '0;
        end
        #12;
        check("reset_outputs", {rd_addr, job_valid, job_in0, job_in1, job_in0F, job_in1F,
                                job_is_output, job_g_logic, job_wire, job_last, job_cc, busy, done}, 0);
        check("reset_stats", {xor_cnt, nonxor_cnt}, 0);
        @(negedge clk); rst_n = 1'b1;

        //        init inp dff gate ncc rdy stall jobs done
        tbl[0] = '{2, 2, 0, 3, 1, 100, 0, 3, 3};   // basic sweep, wires 4,5,6
        tbl[1] = '{2, 2, 0, 3, 1, 100, 2, 3, 8};   // job 2 stalled 5 cycles
        tbl[2] = '{1, 3, 2, 2, 3, 100, 0, 6, 6};   // sequential, three cycles
        tbl[3] = '{2, 2, 0, 0, 1, 100, 0, 0, 0};   // empty circuit
        tbl[4] = '{2, 2, 0, 3, 0, 100, 0, 3, 3};   // num_cc = 0 behaves as 1
        tbl[5] = '{5, 4, 3, 1, 2, 100, 0, 2, 2};   // single gate, wrap every job
        for (int i = 0; i < 6; i++) begin
            run(tbl[i], nj, dc);
            check("job_count", nj, tbl[i].exp_jobs);
            check("done_cycle", dc, tbl[i].exp_done);
        end

        fixed_gl = 1'b1;
        m_gl[0] = 4'b0110; m_gl[1] = 4'b1000; m_gl[2] = 4'b1001; m_gl[3] = 4'b0111;
        v = '{2, 2, 0, 4, 1, 100, 0, 4, 4};
        run(v, nj, dc);
`ifdef GATE_STATS_EN
        check("stats_xor_fixed", xor_cnt, 2);
        check("stats_nonxor_fixed", nonxor_cnt, 2);
`else
        check("stats_off_fixed", {xor_cnt, nonxor_cnt}, 0);
`endif
        fixed_gl = 1'b0;

        // Asynchronous reset while job 2 is on the interface.
        init_size = 14'd2; input_size = 14'd2; dff_size = 14'd1; gate_size = 14'd4; num_cc = 16'd2;
        job_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("pre_reset_job2_wire", {job_valid, job_wire}, {1'b1, 14'd6});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {rd_addr, job_valid, job_wire, job_last, job_cc, busy, done,
                                      job_in0, job_in1, job_g_logic}, 0);
        @(negedge clk); #1;
        check("reset_no_done", done, 0);
        rst_n = 1'b1;
        v = '{2, 2, 1, 4, 2, 100, 0, 8, 8};
        run(v, nj, dc);
        check("restart_job_count", nj, 8);

        for (int i = 0; i < 8; i++) begin
            v.init = $urandom_range(0, 20);  v.inp = $urandom_range(0, 20);
            v.dff  = $urandom_range(0, 5);   v.gate = $urandom_range(0, 8);
            v.ncc  = $urandom_range(0, 3);   v.ready_pct = $urandom_range(40, 90);
            v.stall_job = 0;
            ncc = (v.ncc == 0) ? 1 : v.ncc;
            v.exp_jobs = v.gate * ncc;
            run(v, nj, dc);
            check("rand_job_count", nj, v.exp_jobs);
            if (v.gate == 0) check("rand_empty_done", dc, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
